// File: rtl/usb_stream_bridge.sv
// USB CDC <-> pin byte bridge: RX/TX FWFT FIFOs, synchronized pin strobes, sticky flags.
// Optional internal loopback is built when USB_STREAM_BRIDGE_LOOPBACK_EN is defined.
module usb_stream_bridge #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       configured_i,
    input  logic                       clr_i,
    input  logic [DATA_W-1:0]          usb_out_data_i,
    input  logic                       usb_out_valid_i,
    output logic                       usb_out_ready_o,
    output logic [DATA_W-1:0]          usb_in_data_o,
    output logic                       usb_in_valid_o,
    input  logic                       usb_in_ready_i,
    output logic [DATA_W-1:0]          pin_rx_data_o,
    output logic                       pin_rx_valid_o,
    input  logic                       pin_rx_ack_i,
    input  logic [DATA_W-1:0]          pin_tx_data_i,
    input  logic                       pin_tx_strobe_i,
    input  logic                       loopback_i,
    output logic [$clog2(DEPTH):0]     rx_level_o,
    output logic [$clog2(DEPTH):0]     tx_level_o,
    output logic                       rx_underflow_o,
    output logic                       tx_overflow_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0]      r_rx_mem [DEPTH];
    logic [DATA_W-1:0]      r_tx_mem [DEPTH];
    logic [PW-1:0]          r_rx_wptr, r_rx_rptr, r_tx_wptr, r_tx_rptr;
    logic [PW-1:0]          r_rx_level, r_tx_level;
    logic [SYNC_STAGES-1:0] r_ack_sync, r_stb_sync;
    logic                   r_ack_hist, r_stb_hist;
    logic                   r_rx_unf, r_tx_ovf;

    logic              w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
    logic              w_ack_edge, w_stb_edge;
    logic              w_lb, w_lb_move, w_pin_en;
    logic              w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic              w_unf_set, w_ovf_set;
    logic [DATA_W-1:0] w_tx_din;
    logic [PW-1:0]     w_rx_wptr_n, w_rx_rptr_n, w_tx_wptr_n, w_tx_rptr_n;

    assign w_rx_empty = (r_rx_wptr == r_rx_rptr);
    assign w_rx_full  = (r_rx_wptr[AW] != r_rx_rptr[AW]) &&
                        (r_rx_wptr[AW-1:0] == r_rx_rptr[AW-1:0]);
    assign w_tx_empty = (r_tx_wptr == r_tx_rptr);
    assign w_tx_full  = (r_tx_wptr[AW] != r_tx_rptr[AW]) &&
                        (r_tx_wptr[AW-1:0] == r_tx_rptr[AW-1:0]);

    assign w_ack_edge = r_ack_sync[SYNC_STAGES-1] & ~r_ack_hist;
    assign w_stb_edge = r_stb_sync[SYNC_STAGES-1] & ~r_stb_hist;

`ifdef USB_STREAM_BRIDGE_LOOPBACK_EN
    assign w_lb      = loopback_i & configured_i;
    assign w_lb_move = w_lb & ~w_rx_empty & ~w_tx_full;
`else
    logic w_unused_loopback;
    assign w_unused_loopback = loopback_i;
    assign w_lb              = 1'b0;
    assign w_lb_move         = 1'b0;
`endif

    // Pin events only count while configured and not looped back.
    assign w_pin_en  = configured_i & ~w_lb;

    assign usb_out_ready_o = ~w_rx_full & configured_i;
    assign usb_in_valid_o  = ~w_tx_empty;
    assign pin_rx_valid_o  = ~w_rx_empty & ~w_lb;
    assign usb_in_data_o   = r_tx_mem[r_tx_rptr[AW-1:0]];
    assign pin_rx_data_o   = r_rx_mem[r_rx_rptr[AW-1:0]];

    assign w_rx_push = usb_out_valid_i & usb_out_ready_o;
    assign w_rx_pop  = (w_ack_edge & w_pin_en & ~w_rx_empty) | w_lb_move;
    assign w_unf_set = w_ack_edge & w_pin_en & w_rx_empty;
    assign w_tx_push = (w_stb_edge & w_pin_en & ~w_tx_full) | w_lb_move;
    assign w_tx_pop  = usb_in_valid_o & usb_in_ready_i;
    assign w_ovf_set = w_stb_edge & w_pin_en & w_tx_full;
    assign w_tx_din  = w_lb_move ? pin_rx_data_o : pin_tx_data_i;

    assign w_rx_wptr_n = configured_i ? r_rx_wptr + PW'(w_rx_push) : '0;
    assign w_rx_rptr_n = configured_i ? r_rx_rptr + PW'(w_rx_pop)  : '0;
    assign w_tx_wptr_n = configured_i ? r_tx_wptr + PW'(w_tx_push) : '0;
    assign w_tx_rptr_n = configured_i ? r_tx_rptr + PW'(w_tx_pop)  : '0;

    assign rx_level_o     = r_rx_level;
    assign tx_level_o     = r_tx_level;
    assign rx_underflow_o = r_rx_unf;
    assign tx_overflow_o  = r_tx_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ack_sync <= '0;
            r_stb_sync <= '0;
            r_ack_hist <= 1'b0;
            r_stb_hist <= 1'b0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], pin_rx_ack_i};
            r_stb_sync <= {r_stb_sync[SYNC_STAGES-2:0], pin_tx_strobe_i};
            r_ack_hist <= r_ack_sync[SYNC_STAGES-1];
            r_stb_hist <= r_stb_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_rx_mem[i] <= '0;
                r_tx_mem[i] <= '0;
            end
        end else begin
            if (w_rx_push)
                r_rx_mem[r_rx_wptr[AW-1:0]] <= usb_out_data_i;
            if (w_tx_push)
                r_tx_mem[r_tx_wptr[AW-1:0]] <= w_tx_din;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rx_wptr  <= '0;
            r_rx_rptr  <= '0;
            r_tx_wptr  <= '0;
            r_tx_rptr  <= '0;
            r_rx_level <= '0;
            r_tx_level <= '0;
            r_rx_unf   <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            r_rx_wptr  <= w_rx_wptr_n;
            r_rx_rptr  <= w_rx_rptr_n;
            r_tx_wptr  <= w_tx_wptr_n;
            r_tx_rptr  <= w_tx_rptr_n;
            r_rx_level <= w_rx_wptr_n - w_rx_rptr_n;
            r_tx_level <= w_tx_wptr_n - w_tx_rptr_n;
            if (w_unf_set)
                r_rx_unf <= 1'b1;
            else if (clr_i)
                r_rx_unf <= 1'b0;
            if (w_ovf_set)
                r_tx_ovf <= 1'b1;
            else if (clr_i)
                r_tx_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_usb_stream_bridge.sv
// Directed bench for usb_stream_bridge: vector table plus multi-cycle corner sequences.
// Exercises the loopback path when USB_STREAM_BRIDGE_LOOPBACK_EN is defined.
module tb_usb_stream_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic       cfg, clr;
    logic [7:0] uo_d;
    logic       uo_v, uo_r;
    logic [7:0] ui_d;
    logic       ui_v, ui_r;
    logic [7:0] prx_d;
    logic       prx_v, ack;
    logic [7:0] ptx_d;
    logic       stb, lb;
    logic [4:0] rx_lvl, tx_lvl;
    logic       unf, ovf;

    int total = 0;
    int bad   = 0;

    usb_stream_bridge #(.DATA_W(8), .DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .configured_i   (cfg),
        .clr_i          (clr),
        .usb_out_data_i (uo_d),
        .usb_out_valid_i(uo_v),
        .usb_out_ready_o(uo_r),
        .usb_in_data_o  (ui_d),
        .usb_in_valid_o (ui_v),
        .usb_in_ready_i (ui_r),
        .pin_rx_data_o  (prx_d),
        .pin_rx_valid_o (prx_v),
        .pin_rx_ack_i   (ack),
        .pin_tx_data_i  (ptx_d),
        .pin_tx_strobe_i(stb),
        .loopback_i     (lb),
        .rx_level_o     (rx_lvl),
        .tx_level_o     (tx_lvl),
        .rx_underflow_o (unf),
        .tx_overflow_o  (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       cfg;
        logic       vld;
        logic [7:0] din;
        logic       rdy;
        logic       pv;
        logic       chkd;
        logic [7:0] d;
        logic [4:0] lvl;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ack_pulse();
        ack = 1'b1;
        tick(3);
        ack = 1'b0;
        tick(3);
    endtask

    task automatic stb_pulse(input logic [7:0] d);
        ptx_d = d;
        stb = 1'b1;
        tick(3);
        stb = 1'b0;
        tick(3);
    endtask

    task automatic usb_pop(input string name, input logic [7:0] exp);
        chk(name, ui_d, exp);
        ui_r = 1'b1;
        tick(1);
        ui_r = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 5'd0};
        vecs[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[2] = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd1};
        vecs[3] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1, 8'hA5, 5'd2};
        vecs[4] = '{1'b0, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 8'h00, 5'd0};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 5'd0};

        rst = 1'b1; cfg = 1'b0; clr = 1'b0;
        uo_d = '0; uo_v = 1'b0; ui_r = 1'b0;
        ack = 1'b0; ptx_d = '0; stb = 1'b0; lb = 1'b0;
        tick(2);
        chk("rst_ready", uo_r, 0);
        chk("rst_rxv", prx_v, 0);
        chk("rst_txv", ui_v, 0);
        chk("rst_rxd", prx_d, 0);
        chk("rst_txd", ui_d, 0);
        chk("rst_lvls", {rx_lvl, tx_lvl}, 0);
        chk("rst_flags", {unf, ovf}, 0);
        rst = 1'b0;
        tick(1);

        for (int i = 0; i < 6; i++) begin
            cfg  = vecs[i].cfg;
            uo_v = vecs[i].vld;
            uo_d = vecs[i].din;
            tick(1);
            chk($sformatf("vec%0d_ready", i), uo_r, vecs[i].rdy);
            chk($sformatf("vec%0d_rxv", i), prx_v, vecs[i].pv);
            chk($sformatf("vec%0d_lvl", i), rx_lvl, vecs[i].lvl);
            if (vecs[i].chkd)
                chk($sformatf("vec%0d_rxd", i), prx_d, vecs[i].d);
        end
        uo_v = 1'b0;

        // Single push then ack latency
        uo_d = 8'hA5; uo_v = 1'b1;
        tick(1);
        uo_v = 1'b0;
        chk("a5_valid", prx_v, 1);
        chk("a5_data", prx_d, 8'hA5);
        ack = 1'b1;
        tick(2);
        chk("ack_not_yet", rx_lvl, 1);
        tick(1);
        chk("ack_popped", rx_lvl, 0);
        chk("ack_valid0", prx_v, 0);
        ack = 1'b0;
        tick(3);

        // Fill RX, drain in order, then underflow
        uo_v = 1'b1;
        for (int i = 0; i < 16; i++) begin
            uo_d = 8'(i);
            tick(1);
        end
        uo_v = 1'b0;
        chk("rxfull_ready", uo_r, 0);
        chk("rxfull_lvl", rx_lvl, 16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("drain%0d_d", i), prx_d, 8'(i));
            ack_pulse();
            chk($sformatf("drain%0d_lvl", i), rx_lvl, 5'(15 - i));
        end
        chk("unf_before", unf, 0);
        ack_pulse();
        chk("unf_set", unf, 1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("unf_clr", unf, 0);

        // Set and clear in the same cycle: set wins
        ack = 1'b1;
        tick(2);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("unf_set_wins", unf, 1);
        ack = 1'b0;
        tick(3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("unf_clr2", unf, 0);

        // Fill TX via strobes, overflow drops 0x55
        for (int i = 0; i < 16; i++)
            stb_pulse(8'(8'h80 + i));
        chk("txfull_lvl", tx_lvl, 16);
        chk("txfull_v", ui_v, 1);
        chk("ovf_before", ovf, 0);
        stb_pulse(8'h55);
        chk("ovf_set", ovf, 1);
        chk("ovf_lvl", tx_lvl, 16);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("ovf_clr", ovf, 0);
        for (int i = 0; i < 16; i++)
            usb_pop($sformatf("txpop%0d", i), 8'(8'h80 + i));
        chk("txempty_v", ui_v, 0);
        chk("txempty_lvl", tx_lvl, 0);

        // Push and pop on the same TX edge
        stb_pulse(8'h01);
        stb_pulse(8'h02);
        stb_pulse(8'h03);
        chk("tx3_lvl", tx_lvl, 3);
        ptx_d = 8'h04;
        stb = 1'b1;
        tick(2);
        ui_r = 1'b1;
        tick(1);
        ui_r = 1'b0;
        chk("simul_lvl", tx_lvl, 3);
        stb = 1'b0;
        tick(3);
        usb_pop("simul_d2", 8'h02);
        usb_pop("simul_d3", 8'h03);
        usb_pop("simul_d4", 8'h04);
        chk("simul_end_lvl", tx_lvl, 0);

        // Drop configured for one cycle
        uo_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            uo_d = 8'(8'h40 + i);
            tick(1);
        end
        uo_v = 1'b0;
        stb_pulse(8'h61);
        stb_pulse(8'h62);
        chk("pre_flush_lvls", {rx_lvl, tx_lvl}, {5'd4, 5'd2});
        ptx_d = 8'h99;
        ack = 1'b1;
        stb = 1'b1;
        tick(2);
        cfg = 1'b0;
        tick(1);
        cfg = 1'b1;
        chk("flush_lvls", {rx_lvl, tx_lvl}, 0);
        chk("flush_flags", {unf, ovf}, 0);
        ack = 1'b0;
        stb = 1'b0;
        tick(3);
        chk("post_flush_lvls", {rx_lvl, tx_lvl}, 0);
        chk("post_flush_ready", uo_r, 1);
        cfg = 1'b0;
        ack_pulse();
        cfg = 1'b1;
        tick(1);
        chk("unconf_ack_noflag", unf, 0);

`ifdef USB_STREAM_BRIDGE_LOOPBACK_EN
        lb = 1'b1;
        uo_v = 1'b1;
        uo_d = 8'h11;
        tick(1);
        uo_d = 8'h22;
        tick(1);
        uo_v = 1'b0;
        tick(3);
        chk("lb_rxv", prx_v, 0);
        chk("lb_rxlvl", rx_lvl, 0);
        chk("lb_txlvl", tx_lvl, 2);
        usb_pop("lb_d11", 8'h11);
        chk("lb_d22", ui_d, 8'h22);
        usb_pop("lb_d22_pop", 8'h22);
        chk("lb_end_lvl", tx_lvl, 0);
        lb = 1'b0;
`else
        lb = 1'b1;
        uo_v = 1'b1;
        uo_d = 8'h11;
        tick(1);
        uo_v = 1'b0;
        tick(2);
        chk("nolb_rxv", prx_v, 1);
        chk("nolb_txv", ui_v, 0);
        chk("nolb_rxd", prx_d, 8'h11);
        ack_pulse();
        chk("nolb_ack_lvl", rx_lvl, 0);
        lb = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
